if_id_buffer: RTL and testbench

//  Fetch->Decode pipeline register. Sits downstream of the fetch-stage CU/PC and upstream of decode.

---
 rtl/isa_defs.sv | 39 +++
 rtl/if_id_buffer.sv | 175 +++++++++++++++++
 tb/tb_if_id_buffer.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/isa_defs.sv
// Shared ISA definitions for the fetch/decode front end.
// Holds opcode constants, instruction-byte field positions, default widths
// and the IF/ID assembly state encoding.
package isa_defs;

  // Default datapath widths.
  localparam int unsigned DW_DEF = 8;
  localparam int unsigned AW_DEF = 8;

  // Opcodes the front end cares about.
  localparam logic [3:0] OP_2B = 4'd12;  // LDM/LDD/STD: opcode byte + immediate/EA byte
  localparam logic [3:0] OP_BR = 4'd11;  // branch group, decoded by the fetch CU via brx

  // Instruction byte layout: [7:4] opcode, [3:2] ra/brx, [1:0] rb.
  localparam int unsigned OPC_MSB = 7;
  localparam int unsigned OPC_LSB = 4;
  localparam int unsigned BRX_MSB = 3;
  localparam int unsigned BRX_LSB = 2;
  localparam int unsigned RB_MSB  = 1;
  localparam int unsigned RB_LSB  = 0;

  // Assembly state: waiting for an opcode byte, or for the second byte
  // of a two-byte instruction.
  typedef enum logic {
    S_OP  = 1'b0,
    S_IMM = 1'b1
  } ifid_state_e;

  // Opcode field of an instruction byte.
  function automatic logic [3:0] opcode_of(input logic [7:0] b);
    return b[OPC_MSB:OPC_LSB];
  endfunction

  // brx / ra field of an instruction byte.
  function automatic logic [1:0] brx_of(input logic [7:0] b);
    return b[BRX_MSB:BRX_LSB];
  endfunction

endpackage

// File: rtl/if_id_buffer.sv
// IF/ID pipeline register for the byte-serial fetch path.
// One-byte instructions pass straight through with one cycle of latency.
// Two-byte instructions (opcode OP_2B) are held for one cycle and then
// emitted as a single {instr, imm} packet, leaving one bubble behind.
// Priority each cycle: reset > flush > stall > fetch.
// Optional feature: define IF_ID_BUBBLE_CNT_EN to add a saturating 16-bit
// bubble_cnt output counting live cycles that leave id_valid low.
module if_id_buffer
  import isa_defs::*;
#(
  parameter int unsigned DW    = DW_DEF,
  parameter int unsigned AW    = AW_DEF,
  parameter logic [3:0]  OP_2B = isa_defs::OP_2B
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [DW-1:0] instr_in,
  input  logic [AW-1:0] pc_in,
  input  logic          fetch_valid,
  input  logic          stall,
  input  logic          flush,
  output logic [3:0]    cu_opcode,
  output logic [1:0]    cu_brx,
  output logic          id_valid,
  output logic [DW-1:0] id_instr,
  output logic [DW-1:0] id_imm,
  output logic [AW-1:0] id_pc,
`ifdef IF_ID_BUBBLE_CNT_EN
  output logic [15:0]   bubble_cnt,
`endif
  output logic          imm_pending
);

  // Architectural state.
  ifid_state_e   state_q,      state_d;
  logic [DW-1:0] hold_instr_q, hold_instr_d;
  logic [AW-1:0] hold_pc_q,    hold_pc_d;
  logic          id_valid_q,   id_valid_d;
  logic [DW-1:0] id_instr_q,   id_instr_d;
  logic [DW-1:0] id_imm_q,     id_imm_d;
  logic [AW-1:0] id_pc_q,      id_pc_d;

  // The opcode of the incoming byte decides whether it starts a pair.
  logic [3:0] in_opcode;
  logic       in_is_2b;

  assign in_opcode = instr_in[OPC_MSB:OPC_LSB];
  assign in_is_2b  = (in_opcode == OP_2B);

  // Next-state logic: flush wins over stall, stall freezes everything.
  always_comb begin
    state_d      = state_q;
    hold_instr_d = hold_instr_q;
    hold_pc_d    = hold_pc_q;
    id_valid_d   = id_valid_q;
    id_instr_d   = id_instr_q;
    id_imm_d     = id_imm_q;
    id_pc_d      = id_pc_q;

    if (flush) begin
      // Drops any half-assembled pair as well as the current packet.
      state_d      = S_OP;
      hold_instr_d = '0;
      hold_pc_d    = '0;
      id_valid_d   = 1'b0;
      id_instr_d   = '0;
      id_imm_d     = '0;
      id_pc_d      = '0;
    end else if (!stall) begin
      unique case (state_q)
        S_OP: begin
          if (fetch_valid && in_is_2b) begin
            // Park the opcode byte; decode sees a bubble this cycle.
            hold_instr_d = instr_in;
            hold_pc_d    = pc_in;
            id_valid_d   = 1'b0;
            state_d      = S_IMM;
          end else if (fetch_valid) begin
            id_instr_d = instr_in;
            id_imm_d   = '0;
            id_pc_d    = pc_in;
            id_valid_d = 1'b1;
          end else begin
            // Nothing fetched: bubble, data registers keep their value.
            id_valid_d = 1'b0;
          end
        end
        S_IMM: begin
          if (fetch_valid) begin
            // Second byte arrived: emit the assembled packet at the
            // PC of the opcode byte.
            id_instr_d = hold_instr_q;
            id_imm_d   = instr_in;
            id_pc_d    = hold_pc_q;
            id_valid_d = 1'b1;
            state_d    = S_OP;
          end else begin
            id_valid_d = 1'b0;
          end
        end
        default: begin
          state_d    = S_OP;
          id_valid_d = 1'b0;
        end
      endcase
    end
  end

  // State and pipeline registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_OP;
      hold_instr_q <= '0;
      hold_pc_q    <= '0;
      id_valid_q   <= 1'b0;
      id_instr_q   <= '0;
      id_imm_q     <= '0;
      id_pc_q      <= '0;
    end else begin
      state_q      <= state_d;
      hold_instr_q <= hold_instr_d;
      hold_pc_q    <= hold_pc_d;
      id_valid_q   <= id_valid_d;
      id_instr_q   <= id_instr_d;
      id_imm_q     <= id_imm_d;
      id_pc_q      <= id_pc_d;
    end
  end

  // Fetch CU feedback: while the immediate is being fetched the CU must
  // keep seeing the parked opcode, not the immediate byte on the bus.
  always_comb begin
    cu_opcode = instr_in[OPC_MSB:OPC_LSB];
    cu_brx    = instr_in[BRX_MSB:BRX_LSB];
    if (state_q == S_IMM) begin
      cu_opcode = hold_instr_q[OPC_MSB:OPC_LSB];
      cu_brx    = hold_instr_q[BRX_MSB:BRX_LSB];
    end
  end

  assign id_valid    = id_valid_q;
  assign id_instr    = id_instr_q;
  assign id_imm      = id_imm_q;
  assign id_pc       = id_pc_q;
  assign imm_pending = (state_q == S_IMM);

`ifdef IF_ID_BUBBLE_CNT_EN
  logic [15:0] bubble_cnt_q, bubble_cnt_d;
  logic        bubble_now;

  // A bubble is a live (not stalled, not flushed) cycle that writes
  // id_valid low; flush-induced invalidation is not counted.
  assign bubble_now = !flush && !stall && !id_valid_d;

  // Saturating increment so the count never wraps back to a small value.
  always_comb begin
    bubble_cnt_d = bubble_cnt_q;
    if (bubble_now && (bubble_cnt_q != 16'hFFFF)) begin
      bubble_cnt_d = bubble_cnt_q + 16'd1;
    end
  end

  // Counter register, cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      bubble_cnt_q <= '0;
    end else begin
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_if_id_buffer.sv
// Self-checking bench for if_id_buffer. Inputs change on the falling edge,
// combinational CU feedback is checked just before the rising edge, and
// registered outputs are checked 1 time unit after it against a queue of
// expected packets produced by a behavioural model.
module tb_if_id_buffer;

  logic       clk = 1'b0;
  logic       reset, fetch_valid, stall, flush;
  logic [7:0] instr_in, pc_in;
  logic [3:0] cu_opcode;
  logic [1:0] cu_brx;
  logic       id_valid, imm_pending;
  logic [7:0] id_instr, id_imm, id_pc;
`ifdef IF_ID_BUBBLE_CNT_EN
  logic [15:0] bubble_cnt;
`endif

  int checks = 0;
  int errors = 0;

  if_id_buffer dut (
    .clk         (clk),
    .reset       (reset),
    .instr_in    (instr_in),
    .pc_in       (pc_in),
    .fetch_valid (fetch_valid),
    .stall       (stall),
    .flush       (flush),
    .cu_opcode   (cu_opcode),
    .cu_brx      (cu_brx),
    .id_valid    (id_valid),
    .id_instr    (id_instr),
    .id_imm      (id_imm),
    .id_pc       (id_pc),
`ifdef IF_ID_BUBBLE_CNT_EN
    .bubble_cnt  (bubble_cnt),
`endif
    .imm_pending (imm_pending)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [7:0]  ins;
    logic [7:0]  imm;
    logic [7:0]  pc;
    logic        pend;
    logic [15:0] bub;
  } exp_t;

  exp_t exp_q[$];

  // Behavioural model of the buffer.
  logic        m_known = 1'b0;
  logic        m_pend;
  logic [7:0]  m_hold, m_hpc;
  logic        m_v;
  logic [7:0]  m_ins, m_imm, m_pc;
  logic [15:0] m_bub;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h t=%0t", tag, got, want, $time);
    end
  endtask

  // One clock of stimulus: drive, check CU feedback, model, check registers.
  task automatic step(input logic rst, input logic fv, input logic [7:0] ins,
                      input logic [7:0] pc, input logic st, input logic fl,
                      input string name);
    exp_t e;
    logic [7:0] cu_src;
    logic       bubble;
    @(negedge clk);
    reset = rst; fetch_valid = fv; instr_in = ins; pc_in = pc; stall = st; flush = fl;
    #4;
    if (m_known) begin
      cu_src = m_pend ? m_hold : ins;
      chk({name, ".cu_opcode"}, {28'd0, cu_opcode}, {28'd0, cu_src[7:4]});
      chk({name, ".cu_brx"},    {30'd0, cu_brx},    {30'd0, cu_src[3:2]});
    end
    // Model update.
    bubble = 1'b0;
    if (rst) begin
      m_known = 1'b1; m_pend = 1'b0; m_hold = 8'h00; m_hpc = 8'h00;
      m_v = 1'b0; m_ins = 8'h00; m_imm = 8'h00; m_pc = 8'h00; m_bub = 16'h0000;
    end else if (fl) begin
      m_pend = 1'b0; m_hold = 8'h00; m_hpc = 8'h00;
      m_v = 1'b0; m_ins = 8'h00; m_imm = 8'h00; m_pc = 8'h00;
    end else if (!st) begin
      if (m_pend) begin
        if (fv) begin
          m_v = 1'b1; m_ins = m_hold; m_imm = ins; m_pc = m_hpc; m_pend = 1'b0;
        end else begin
          m_v = 1'b0; bubble = 1'b1;
        end
      end else if (fv && ins[7:4] == 4'd12) begin
        m_hold = ins; m_hpc = pc; m_pend = 1'b1; m_v = 1'b0; bubble = 1'b1;
      end else if (fv) begin
        m_v = 1'b1; m_ins = ins; m_imm = 8'h00; m_pc = pc;
      end else begin
        m_v = 1'b0; bubble = 1'b1;
      end
      if (bubble && m_bub != 16'hFFFF) m_bub = m_bub + 16'd1;
    end
    e.v = m_v; e.ins = m_ins; e.imm = m_imm; e.pc = m_pc; e.pend = m_pend; e.bub = m_bub;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      chk({name, ".queue"}, 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      chk({name, ".id_valid"},    {31'd0, id_valid},    {31'd0, e.v});
      chk({name, ".id_instr"},    {24'd0, id_instr},    {24'd0, e.ins});
      chk({name, ".id_imm"},      {24'd0, id_imm},      {24'd0, e.imm});
      chk({name, ".id_pc"},       {24'd0, id_pc},       {24'd0, e.pc});
      chk({name, ".imm_pending"}, {31'd0, imm_pending}, {31'd0, e.pend});
`ifdef IF_ID_BUBBLE_CNT_EN
      chk({name, ".bubble_cnt"},  {16'd0, bubble_cnt},  {16'd0, e.bub});
`endif
      $display("txn %-10s rst=%0b fv=%0b in=%02h pc=%02h st=%0b fl=%0b -> v=%0b ins=%02h imm=%02h pc=%02h pend=%0b",
               name, rst, fv, ins, pc, st, fl, id_valid, id_instr, id_imm, id_pc, imm_pending);
    end
  endtask

  initial begin
    logic [7:0] r;
    reset = 1'b1; fetch_valid = 1'b0; instr_in = 8'h00; pc_in = 8'h00;
    stall = 1'b0; flush = 1'b0;

    // 1: reset then a one-byte instruction.
    step(1, 0, 8'h00, 8'h00, 0, 0, "rst0");
    step(1, 0, 8'h00, 8'h00, 0, 0, "rst1");
    step(0, 1, 8'h15, 8'h03, 0, 0, "t1_15");
    chk("t1.instr_abs", {24'd0, id_instr}, 32'h15);

    // 2: two-byte instruction assembled with one bubble.
    step(0, 1, 8'hC4, 8'h05, 0, 0, "t2_c4");
    chk("t2.pend_abs", {31'd0, imm_pending}, 32'd1);
    step(0, 1, 8'h7A, 8'h06, 0, 0, "t2_7a");
    chk("t2.imm_abs", {24'd0, id_imm}, 32'h7A);

    // 3: stall in S_IMM freezes everything; bus contents ignored.
    step(0, 1, 8'hC4, 8'h10, 0, 0, "t3_c4");
    step(0, 1, 8'h99, 8'h11, 1, 0, "t3_st0");
    step(0, 1, 8'hAA, 8'h11, 1, 0, "t3_st1");
    step(0, 1, 8'hBB, 8'h11, 1, 0, "t3_st2");
    step(0, 1, 8'h33, 8'h11, 0, 0, "t3_33");
    chk("t3.imm_abs", {24'd0, id_imm}, 32'h33);

    // 4: flush with stall in S_IMM drops the pair.
    step(0, 1, 8'hC8, 8'h20, 0, 0, "t4_c8");
    step(0, 1, 8'h55, 8'h21, 1, 1, "t4_fl");
    chk("t4.pend_abs", {31'd0, imm_pending}, 32'd0);
    step(0, 1, 8'h21, 8'h22, 0, 0, "t4_21");
    chk("t4.imm_abs", {24'd0, id_imm}, 32'h00);

    // 5: two fetch bubbles in S_OP.
    step(0, 0, 8'h44, 8'h30, 0, 0, "t5_b0");
    step(0, 0, 8'h45, 8'h31, 0, 0, "t5_b1");

    // Bubble inside S_IMM keeps the parked byte.
    step(0, 1, 8'hCD, 8'h40, 0, 0, "t5_cd");
    step(0, 0, 8'h00, 8'h41, 0, 0, "t5_gap");
    step(0, 1, 8'hEE, 8'h41, 0, 0, "t5_ee");

    // 6: reset in S_IMM discards the parked byte.
    step(0, 1, 8'hC4, 8'h50, 0, 0, "t6_c4");
    step(1, 1, 8'h7A, 8'h51, 0, 0, "t6_rst");
    chk("t6.valid_abs", {31'd0, id_valid}, 32'd0);
    step(0, 1, 8'h12, 8'h52, 0, 0, "t6_12");

    // Randomised traffic, biased towards two-byte opcodes.
    for (int i = 0; i < 200; i++) begin
      r = 8'($urandom);
      if ($urandom_range(0, 3) == 0) r[7:4] = 4'd12;
      step(0, ($urandom_range(0, 4) != 0), r, 8'($urandom),
           ($urandom_range(0, 6) == 0), ($urandom_range(0, 12) == 0), "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Absolute time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
